pixel_slot_scheduler: RTL and testbench
=======================================

# pixel_slot_scheduler

Issue scheduler for the pipelined Mandelbrot/Julia iteration datapath. The datapath is a LANES-deep pipeline: a point issued in one cycle returns its diverged flag exactly LANES cycles later. The scheduler keeps LANES independent pixel slots in flight and refills each slot as soon as its pixel retires, instead of waiting for all lanes to finish. It sits between the frame controls and the mapper/ALU on the issue side, and the RGB/frame-buffer writer on the output side.

## Interface
- LANES, 4: pipeline depth = number of slots (power of two, 2..8)
- CW, 10: pixel coordinate width
- IW, 24: iteration count width
- aclk  in  1  clock
- aresetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE)
- x_size, y_size  in  CW  frame dimensions, latched on accepted start
- max_iter  in  IW  iteration limit, latched on accepted start; 0 treated as 1
- iss_valid  out  1  issue slot this cycle
- iss_load  out  1  1 = new point (datapath loads z0/c from iss_x/iss_y); 0 = continue iterating
- iss_slot  out  log2(LANES)  slot at pipeline head
- iss_x, iss_y  out  CW  coordinates of issued point
- div  in  1  diverged flag for the head slot's point issued LANES cycles earlier; sampled only when that issue was valid
- pix_valid / pix_ready  out/in  1  output handshake
- pix_x, pix_y  out  CW; pix_count  out  IW  retired pixel
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse when frame fully retired

## Operation
- States: IDLE -> RUN on start; RUN -> DRAIN when the last raster pixel has been loaded; DRAIN -> IDLE when all slots are empty and the output register is empty; frame_done pulses on that transition.
- Head pointer p increments mod LANES every cycle in RUN/DRAIN; it is 0 in IDLE.
- Per slot: occupied, issued, x, y, count (IW).
- Head slot decision, in priority order:
  - Returning result (issued=1): count_new = count+1. If div=1 or count_new == max_iter, the slot retires with pix_count = count_new, then reloads.
  - Returning result, not retiring: issue continue (iss_load=0); count = count_new.
  - Retire blocked (output register full and not being drained this cycle): issue bubble (iss_valid=0); the slot holds its done result (issued cleared, done flag set) and retries on the next revolution.
  - Reload/empty slot: if raster pixels remain, load the next pixel (iss_load=1, count=0); otherwise the slot becomes empty with iss_valid=0.
- Raster generator: x counts fastest, 0..x_size-1, then y increments; the last pixel is (x_size-1, y_size-1). Output order is completion order, not raster order.
- Empty frame (x_size or y_size == 0): RUN lasts one cycle with no issues, then DRAIN -> IDLE and frame_done.
- Output register is one entry. A retire may load it in the same cycle pix_ready empties it.
- Counts saturate at max_iter and never wrap.

## Timing
- Reset values: all outputs 0, state IDLE, all slots empty, raster counters 0.
- Start accepted at cycle T: first load issue at T+1 with iss_slot=0, (0,0).
- A point loaded at cycle L returns at L+LANES. If it retires with no backpressure, pix_valid rises at L+LANES+1.
- Issue throughput: 1 per cycle. Retire throughput: at most 1 per cycle.
- pix_* stable while pix_valid=1 and pix_ready=0.
- A start pulse while busy is ignored.
- Reset asserted mid-frame: immediate return to IDLE; in-flight pipeline results are discarded (issued flags cleared).
- frame_done is asserted the cycle after the last pixel handshake completes.

## Structure
- Shared package mandel_pkg: state enum {IDLE, RUN, DRAIN}; slot record typedef (occupied, issued, done, x, y, count); default widths CW/IW.
- One sub-module: raster_gen (x/y counters; outputs next coordinate and last flag; advances on load).

## Test plan
- Frame 4x1, max_iter=8, div=1 on every first return, pix_ready=1 -> four pixels with count=1; first pix_valid at T+LANES+2; frame_done after the 4th handshake.
- Frame 2x2, div never asserted, max_iter=3 -> each pixel count=3; each slot issues load, continue, continue, then retires.
- Mixed: slot 0 diverges at 1 iteration, slot 1 at 5, max_iter=10, frame 6x1 -> pixels 4 and 5 load into slot 0 before slot 1 retires; outputs carry correct coordinates in completion order.
- pix_ready=0 for 20 cycles mid-frame -> the register holds the first pixel, other retiring slots issue bubbles, no pixel is lost or duplicated, and the total count equals x_size*y_size.
- x_size=0 -> no iss_valid; frame_done 2 cycles after start.
- aresetn pulsed mid-frame, then a new start -> all outputs 0 during reset; the new frame starts at (0,0) with no stale pixels.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot/Julia issue side: scheduler states,
// default coordinate/iteration widths and the default-width slot record.
package mandel_pkg;

    localparam int MANDEL_CW = 10;
    localparam int MANDEL_IW = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                 occupied;
        logic                 issued;
        logic                 done;
        logic [MANDEL_CW-1:0] x;
        logic [MANDEL_CW-1:0] y;
        logic [MANDEL_IW-1:0] count;
    } slot_t;

endpackage

// File: rtl/raster_gen.sv
// Raster walker: x fastest, then y. Presents the next pixel to load and
// whether it is the last one; advances only when that pixel is loaded.
module raster_gen #(
    parameter int CW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          init_i,
    input  logic [CW-1:0] x_size_i,
    input  logic [CW-1:0] y_size_i,
    input  logic          adv_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          last_o,
    output logic          pending_o
);

    logic [CW-1:0] xs_q, xs_d, ys_q, ys_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          pend_q, pend_d;
    logic          last_s, x_wrap_s;

    // Counter next-state; an empty frame never becomes pending
    always_comb begin
        xs_d     = xs_q;
        ys_d     = ys_q;
        x_d      = x_q;
        y_d      = y_q;
        pend_d   = pend_q;
        x_wrap_s = (x_q == (xs_q - CW'(1)));
        last_s   = x_wrap_s && (y_q == (ys_q - CW'(1)));
        if (init_i) begin
            xs_d   = x_size_i;
            ys_d   = y_size_i;
            x_d    = '0;
            y_d    = '0;
            pend_d = (x_size_i != '0) && (y_size_i != '0);
        end else if (adv_i && pend_q) begin
            if (last_s) begin
                pend_d = 1'b0;
                x_d    = '0;
                y_d    = '0;
            end else if (x_wrap_s) begin
                x_d = '0;
                y_d = y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end else begin
            pend_d = pend_q;
        end
    end

    // Raster state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xs_q   <= '0;
            ys_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            pend_q <= 1'b0;
        end else begin
            xs_q   <= xs_d;
            ys_q   <= ys_d;
            x_q    <= x_d;
            y_q    <= y_d;
            pend_q <= pend_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign last_o    = last_s;
    assign pending_o = pend_q;

endmodule

// File: rtl/pixel_slot_scheduler.sv
// Keeps LANES pixels in flight through the iteration pipeline and refills
// each slot as soon as its pixel retires into the one-entry output register.
module pixel_slot_scheduler
    import mandel_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CW    = MANDEL_CW,
    parameter int IW    = MANDEL_IW,
    localparam int SW   = $clog2(LANES)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic [CW-1:0] x_size,
    input  logic [CW-1:0] y_size,
    input  logic [IW-1:0] max_iter,
    output logic          iss_valid,
    output logic          iss_load,
    output logic [SW-1:0] iss_slot,
    output logic [CW-1:0] iss_x,
    output logic [CW-1:0] iss_y,
    input  logic          div,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [IW-1:0] pix_count,
    output logic          busy,
    output logic          frame_done
);

    typedef struct packed {
        logic          occupied;
        logic          issued;
        logic          done;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [IW-1:0] count;
    } lane_slot_t;

    sched_state_e            state_q, state_d;
    logic [SW-1:0]           p_q, p_d;
    lane_slot_t [LANES-1:0]  slot_q, slot_d;
    logic [IW-1:0]           max_iter_q, max_iter_d;
    logic                    out_valid_q, out_valid_d;
    logic [CW-1:0]           out_x_q, out_x_d, out_y_q, out_y_d;
    logic [IW-1:0]           out_count_q, out_count_d;
    logic                    frame_done_q, frame_done_d;

    logic                    start_acc_s;
    logic                    ras_adv_s, ras_last_s, ras_pend_s;
    logic [CW-1:0]           ras_x_s, ras_y_s;
    lane_slot_t              head_s;
    logic [IW-1:0]           count_new_s, ret_count_s;
    logic                    out_free_s, retire_s, reload_s;
    logic                    iss_valid_s, iss_load_s;
    logic [CW-1:0]           iss_x_s, iss_y_s;
    logic                    all_empty_now_s, all_empty_next_s;

    assign start_acc_s = start && (state_q == IDLE);

    raster_gen #(.CW(CW)) u_raster (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .init_i    (start_acc_s),
        .x_size_i  (x_size),
        .y_size_i  (y_size),
        .adv_i     (ras_adv_s),
        .x_o       (ras_x_s),
        .y_o       (ras_y_s),
        .last_o    (ras_last_s),
        .pending_o (ras_pend_s)
    );

    // Head-slot decision: retire, continue, hold as bubble, or reload
    always_comb begin
        slot_d      = slot_q;
        head_s      = slot_q[p_q];
        count_new_s = head_s.count + IW'(1);
        out_free_s  = !out_valid_q || pix_ready;
        iss_valid_s = 1'b0;
        iss_load_s  = 1'b0;
        iss_x_s     = '0;
        iss_y_s     = '0;
        retire_s    = 1'b0;
        ret_count_s = '0;
        reload_s    = 1'b0;
        ras_adv_s   = 1'b0;
        if (state_q == IDLE) begin
            if (start_acc_s) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q;
            end
        end else begin
            if (head_s.issued) begin
                // count_new can reach max_iter but never pass it
                if (div || (count_new_s >= max_iter_q)) begin
                    if (out_free_s) begin
                        retire_s    = 1'b1;
                        ret_count_s = count_new_s;
                        reload_s    = 1'b1;
                    end else begin
                        slot_d[p_q].issued = 1'b0;
                        slot_d[p_q].done   = 1'b1;
                        slot_d[p_q].count  = count_new_s;
                    end
                end else begin
                    iss_valid_s       = 1'b1;
                    iss_x_s           = head_s.x;
                    iss_y_s           = head_s.y;
                    slot_d[p_q].count = count_new_s;
                end
            end else if (head_s.done) begin
                if (out_free_s) begin
                    retire_s    = 1'b1;
                    ret_count_s = head_s.count;
                    reload_s    = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
            end else begin
                reload_s = 1'b1;
            end
            if (reload_s) begin
                if (ras_pend_s) begin
                    iss_valid_s          = 1'b1;
                    iss_load_s           = 1'b1;
                    iss_x_s              = ras_x_s;
                    iss_y_s              = ras_y_s;
                    ras_adv_s            = 1'b1;
                    slot_d[p_q].occupied = 1'b1;
                    slot_d[p_q].issued   = 1'b1;
                    slot_d[p_q].done     = 1'b0;
                    slot_d[p_q].x        = ras_x_s;
                    slot_d[p_q].y        = ras_y_s;
                    slot_d[p_q].count    = '0;
                end else begin
                    slot_d[p_q] = '0;
                end
            end else begin
                ras_adv_s = 1'b0;
            end
        end
    end

    // Output register: a retire may refill it in the same cycle it drains
    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_count_d = out_count_q;
        if (retire_s) begin
            out_valid_d = 1'b1;
            out_x_d     = head_s.x;
            out_y_d     = head_s.y;
            out_count_d = ret_count_s;
        end else if (pix_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Frame sequencing, head pointer and the done pulse
    always_comb begin
        all_empty_now_s  = 1'b1;
        all_empty_next_s = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            all_empty_now_s  = all_empty_now_s  & ~slot_q[i].occupied;
            all_empty_next_s = all_empty_next_s & ~slot_d[i].occupied;
        end
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!ras_pend_s || (ras_adv_s && ras_last_s)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (all_empty_now_s && !out_valid_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && (state_d != IDLE)) begin
            p_d = p_q + SW'(1);
        end else begin
            p_d = '0;
        end
        if (start_acc_s) begin
            max_iter_d = (max_iter == '0) ? IW'(1) : max_iter;
        end else begin
            max_iter_d = max_iter_q;
        end
        // Registered so it lands in the very cycle DRAIN->IDLE is taken
        frame_done_d = (state_d == DRAIN) && all_empty_next_s && !out_valid_d;
    end

    // Scheduler state registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            p_q          <= '0;
            slot_q       <= '0;
            max_iter_q   <= IW'(1);
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            slot_q       <= slot_d;
            max_iter_q   <= max_iter_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_count_q  <= out_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign iss_valid  = iss_valid_s;
    assign iss_load   = iss_load_s;
    assign iss_slot   = p_q;
    assign iss_x      = iss_x_s;
    assign iss_y      = iss_y_s;
    assign pix_valid  = out_valid_q;
    assign pix_x      = out_x_q;
    assign pix_y      = out_y_q;
    assign pix_count  = out_count_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_slot_scheduler.sv
// Directed bench: a small datapath model drives div from per-pixel
// divergence iterations; results are compared with hand-derived tables.
module tb_pixel_slot_scheduler;

    localparam int LANES = 4;
    localparam int CW    = 10;
    localparam int IW    = 24;

    logic          aclk = 1'b0;
    logic          aresetn, start, div, pix_ready;
    logic [CW-1:0] x_size, y_size;
    logic [IW-1:0] max_iter;
    logic          iss_valid, iss_load, pix_valid, busy, frame_done;
    logic [1:0]    iss_slot;
    logic [CW-1:0] iss_x, iss_y, pix_x, pix_y;
    logic [IW-1:0] pix_count;

    pixel_slot_scheduler #(.LANES(LANES), .CW(CW), .IW(IW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .x_size(x_size), .y_size(y_size), .max_iter(max_iter),
        .iss_valid(iss_valid), .iss_load(iss_load), .iss_slot(iss_slot),
        .iss_x(iss_x), .iss_y(iss_y), .div(div),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_count(pix_count),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    typedef struct { bit v; int x; int y; } pipe_t;
    typedef struct { int x; int y; int c; } pix_t;

    int     cyc = 0;
    int     n_cmp = 0, n_mis = 0;
    int     div_at[64];
    int     ret[64];
    pipe_t  pipe[4];
    pix_t   out_q[$];
    longint load_q[$];
    longint exp_q[$];
    int     start_cyc, first_iss_cyc, first_pv_cyc, done_cyc;
    int     first_iss_slot, first_iss_load, first_iss_x, first_iss_y;
    int     n_done, n_iss, n_load, n_cont, stall_changes;
    bit     prev_stall;
    longint prev_pk;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic longint pk(input int x, input int y, input int c);
        return longint'(x) * 1000000 + longint'(y) * 1000 + longint'(c);
    endfunction

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Datapath model and output monitor
    initial begin
        div = 1'b0;
        for (int i = 0; i < 4; i++) pipe[i] = '{v: 1'b0, x: 0, y: 0};
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                div = 1'b0;
                for (int i = 0; i < 4; i++) pipe[i].v = 1'b0;
            end else if (pipe[3].v) begin
                int idx;
                idx = (pipe[3].y * 8 + pipe[3].x) & 63;
                ret[idx]++;
                div = (ret[idx] >= div_at[idx]);
            end else begin
                div = 1'b0;
            end
            #1;
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{v: (iss_valid && aresetn), x: int'(iss_x), y: int'(iss_y)};
            if (iss_valid) begin
                n_iss++;
                if (first_iss_cyc < 0) begin
                    first_iss_cyc  = cyc;
                    first_iss_slot = int'(iss_slot);
                    first_iss_load = int'(iss_load);
                    first_iss_x    = int'(iss_x);
                    first_iss_y    = int'(iss_y);
                end
                if (iss_load) begin
                    n_load++;
                    ret[(int'(iss_y) * 8 + int'(iss_x)) & 63] = 0;
                    load_q.push_back(longint'(iss_slot) * 100 + longint'(iss_x));
                end else begin
                    n_cont++;
                end
            end
            if (pix_valid && first_pv_cyc < 0) first_pv_cyc = cyc;
            if (pix_valid && pix_ready)
                out_q.push_back('{x: int'(pix_x), y: int'(pix_y), c: int'(pix_count)});
            if (pix_valid && !pix_ready) begin
                if (prev_stall && pk(int'(pix_x), int'(pix_y), int'(pix_count)) != prev_pk)
                    stall_changes++;
                prev_stall = 1'b1;
                prev_pk    = pk(int'(pix_x), int'(pix_y), int'(pix_count));
            end else begin
                prev_stall = 1'b0;
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic set_div_all(input int d);
        for (int i = 0; i < 64; i++) div_at[i] = d;
    endtask

    task automatic start_frame(input int xs, input int ys, input int mi);
        first_iss_cyc = -1; first_pv_cyc = -1; done_cyc = -1;
        n_done = 0; n_iss = 0; n_load = 0; n_cont = 0; stall_changes = 0;
        out_q.delete(); load_q.delete();
        @(negedge aclk);
        x_size    = CW'(xs);
        y_size    = CW'(ys);
        max_iter  = IW'(mi);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge aclk);
            #2;
            k++;
        end
        repeat (3) @(negedge aclk);
        #2;
        check_eq({tag, "_done_pulses"}, n_done, 1);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_outs(input string tag);
        check_eq({tag, "_npix"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            longint act;
            act = (i < out_q.size()) ? pk(out_q[i].x, out_q[i].y, out_q[i].c) : -1;
            check_eq($sformatf("%s_pix%0d", tag, i), act, exp_q[i]);
        end
    endtask

    function automatic longint all_outs();
        return longint'({iss_valid, iss_load, iss_slot, iss_x, iss_y, pix_valid,
                         pix_x, pix_y, pix_count, busy, frame_done} != '0);
    endfunction

    initial begin
        aresetn = 1'b0; start = 1'b0; pix_ready = 1'b1;
        x_size = '0; y_size = '0; max_iter = '0;
        prev_stall = 1'b0; prev_pk = 0;
        set_div_all(1000);
        for (int i = 0; i < 64; i++) ret[i] = 0;
        first_iss_cyc = -1; first_pv_cyc = -1; done_cyc = -1; n_done = 0;
        #1;
        check_eq("reset_outs", all_outs(), 0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // 4x1, every pixel diverges on its first return
        set_div_all(1);
        start_frame(4, 1, 8);
        wait_done("t1", 100);
        check_eq("t1_first_iss_ofs", first_iss_cyc - start_cyc, 1);
        check_eq("t1_first_iss_slot", first_iss_slot, 0);
        check_eq("t1_first_iss_load", first_iss_load, 1);
        check_eq("t1_first_iss_xy", pk(first_iss_x, first_iss_y, 0), pk(0, 0, 0));
        check_eq("t1_first_pv_ofs", first_pv_cyc - start_cyc, LANES + 2);
        check_eq("t1_done_ofs", done_cyc - start_cyc, 10);
        exp_q = '{pk(0,0,1), pk(1,0,1), pk(2,0,1), pk(3,0,1)};
        check_outs("t1");

        // 2x2, never diverges, limit 3; a start mid-frame must be ignored
        set_div_all(1000);
        start_frame(2, 2, 3);
        repeat (4) @(negedge aclk);
        x_size = CW'(7); y_size = CW'(7); max_iter = IW'(1); start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_done("t2", 100);
        check_eq("t2_loads", n_load, 4);
        check_eq("t2_continues", n_cont, 8);
        check_eq("t2_done_ofs", done_cyc - start_cyc, 18);
        exp_q = '{pk(0,0,3), pk(1,0,3), pk(0,1,3), pk(1,1,3)};
        check_outs("t2");

        // 6x1 mixed divergence, limit 10
        set_div_all(1000);
        div_at[0] = 1; div_at[1] = 5; div_at[2] = 3; div_at[3] = 2;
        div_at[4] = 1; div_at[5] = 1;
        start_frame(6, 1, 10);
        wait_done("t3", 100);
        check_eq("t3_load4_slot_x", (load_q.size() > 4) ? load_q[4] : -1, 4);
        check_eq("t3_load5_slot_x", (load_q.size() > 5) ? load_q[5] : -1, 5);
        check_eq("t3_done_ofs", done_cyc - start_cyc, 24);
        exp_q = '{pk(0,0,1), pk(4,0,1), pk(3,0,2), pk(5,0,1), pk(2,0,3), pk(1,0,5)};
        check_outs("t3");

        // 8x1 with output stalled for 20 cycles
        set_div_all(1);
        start_frame(8, 1, 4);
        pix_ready = 1'b0;
        repeat (19) @(negedge aclk);
        #2;
        check_eq("t4_stall_held", pk(int'(pix_valid), int'(pix_x), 0), pk(1, 0, 0));
        check_eq("t4_stall_issues", n_iss, 5);
        @(negedge aclk);
        pix_ready = 1'b1;
        wait_done("t4", 100);
        check_eq("t4_stall_changes", stall_changes, 0);
        check_eq("t4_done_ofs", done_cyc - start_cyc, 29);
        exp_q = '{pk(0,0,1), pk(4,0,1), pk(1,0,1), pk(2,0,1),
                  pk(3,0,1), pk(5,0,1), pk(6,0,1), pk(7,0,1)};
        check_outs("t4");

        // Empty frame
        start_frame(0, 3, 5);
        wait_done("t5", 50);
        check_eq("t5_issues", n_iss, 0);
        check_eq("t5_done_ofs", done_cyc - start_cyc, 2);
        check_eq("t5_npix", out_q.size(), 0);

        // Reset mid-frame, then a fresh frame with max_iter=0 (acts as 1)
        set_div_all(1000);
        start_frame(4, 1, 8);
        repeat (6) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_eq("t6_reset_outs", all_outs(), 0);
        repeat (2) @(negedge aclk);
        #1;
        check_eq("t6_reset_hold", all_outs(), 0);
        aresetn = 1'b1;
        @(negedge aclk);
        start_frame(2, 1, 0);
        wait_done("t6", 100);
        check_eq("t6_first_iss_ofs", first_iss_cyc - start_cyc, 1);
        check_eq("t6_first_iss", pk(first_iss_slot, first_iss_x * 10 + first_iss_y, first_iss_load),
                 pk(0, 0, 1));
        check_eq("t6_done_ofs", done_cyc - start_cyc, 8);
        exp_q = '{pk(0,0,1), pk(1,0,1)};
        check_outs("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
